// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder: reads back a time-multiplexed 4-digit seven-segment drive.
// A {digit, font} pair must be held steady for STABLE_CYCLES edges before it is
// accepted. Accepted digits fill a shadow frame. Once all four digits have been
// seen, the shadow frame is copied to the registered outputs. A partial frame is
// dropped if no non-blank accept arrives for TIMEOUT_CYCLES edges.
module fnd_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_digit,
    input  logic [7:0]  i_font,
    output logic [15:0] o_value,
    output logic [3:0]  o_dp,
    output logic [3:0]  o_blank,
    output logic        o_frame_valid,
    output logic        o_seg_error,
    output logic        o_timeout
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_LAST  = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX   = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);

    logic [11:0]   held;
    logic [SW-1:0] stable_cnt;
    logic [TW-1:0] idle_cnt;
    logic [3:0]    seen;
    logic [15:0]   shadow_value;
    logic [3:0]    shadow_dp;
    logic [3:0]    shadow_blank;

    logic [11:0] pair_in;
    logic        same;
    logic        accept;
    logic        slot_valid;
    logic [1:0]  slot_idx;
    logic        digit_err;
    logic        digit_blank;
    logic        font_ok;
    logic        font_blank;
    logic [3:0]  font_val;
    logic        accept_slot;
    logic        accept_err;
    logic        accept_live;
    logic        commit;
    logic        timeout_fire;
    logic [3:0]  seen_base;

    assign pair_in = {i_digit, i_font};
    assign same    = (pair_in == held);
    // Fires only on the edge the count reaches STABLE_CYCLES; it saturates after that.
    assign accept  = same && (stable_cnt == STABLE_LAST);

    // Digit select: exactly one low bit selects a slot, all-high is blanking.
    always_comb begin
        slot_valid  = 1'b0;
        slot_idx    = 2'd0;
        digit_err   = 1'b0;
        digit_blank = 1'b0;
        case (i_digit)
            4'hE:    begin slot_valid = 1'b1; slot_idx = 2'd0; end
            4'hD:    begin slot_valid = 1'b1; slot_idx = 2'd1; end
            4'hB:    begin slot_valid = 1'b1; slot_idx = 2'd2; end
            4'h7:    begin slot_valid = 1'b1; slot_idx = 2'd3; end
            4'hF:    digit_blank = 1'b1;
            default: digit_err   = 1'b1;
        endcase
    end

    // Active-low segment patterns {g,f,e,d,c,b,a} to hex value, 7F is a dark digit.
    always_comb begin
        font_ok    = 1'b1;
        font_blank = 1'b0;
        font_val   = 4'h0;
        case (i_font[6:0])
            7'h40: font_val = 4'h0;
            7'h79: font_val = 4'h1;
            7'h24: font_val = 4'h2;
            7'h30: font_val = 4'h3;
            7'h19: font_val = 4'h4;
            7'h12: font_val = 4'h5;
            7'h02: font_val = 4'h6;
            7'h78: font_val = 4'h7;
            7'h00: font_val = 4'h8;
            7'h10: font_val = 4'h9;
            7'h08: font_val = 4'hA;
            7'h03: font_val = 4'hB;
            7'h46: font_val = 4'hC;
            7'h21: font_val = 4'hD;
            7'h06: font_val = 4'hE;
            7'h0E: font_val = 4'hF;
            7'h7F: font_blank = 1'b1;
            default: font_ok = 1'b0;
        endcase
    end

    assign accept_slot  = accept && slot_valid && font_ok;
    assign accept_err   = accept && (digit_err || (slot_valid && !font_ok));
    assign accept_live  = accept && !digit_blank;
    assign commit       = (seen == 4'hF);
    // A non-blank accept on the same edge wins over the timeout.
    assign timeout_fire = !commit && !accept_live && (idle_cnt == TIMEOUT_LAST) && (seen != 4'h0);

    // Commit and timeout both start an empty frame; an accept on that edge lands in it.
    always_comb begin
        seen_base = seen;
        if (commit || timeout_fire) begin
            seen_base = 4'h0;
        end
    end

    // Stability filter: reload on any change, count identical edges up to saturation.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            held       <= {4'hF, 8'hFF};
            stable_cnt <= '0;
        end else if (!same) begin
            held       <= pair_in;
            stable_cnt <= SW'(1);
        end else if (stable_cnt != STABLE_MAX) begin
            stable_cnt <= stable_cnt + SW'(1);
        end
    end

    // Idle timer: restarts on every non-blank accept and holds at its limit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idle_cnt <= '0;
        end else if (accept_live) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TIMEOUT_MAX) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    // Shadow frame fill, frame commit and the three event pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            seen          <= 4'h0;
            shadow_value  <= 16'h0000;
            shadow_dp     <= 4'h0;
            shadow_blank  <= 4'h0;
            o_value       <= 16'h0000;
            o_dp          <= 4'h0;
            o_blank       <= 4'h0;
            o_frame_valid <= 1'b0;
            o_seg_error   <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            o_frame_valid <= commit;
            o_seg_error   <= accept_err;
            o_timeout     <= timeout_fire;
            if (commit) begin
                o_value <= shadow_value;
                o_dp    <= shadow_dp;
                o_blank <= shadow_blank;
            end
            if (accept_slot) begin
                shadow_value[{slot_idx, 2'b00} +: 4] <= font_val;
                shadow_dp[slot_idx]                  <= ~i_font[7];
                shadow_blank[slot_idx]               <= font_blank;
                seen <= seen_base | (4'b0001 << slot_idx);
            end else begin
                seen <= seen_base;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Bench for fnd_scan_decoder: table of single-digit decode vectors plus
// hand-written multi-cycle sequences; all pulses go through a scoreboard queue.
module tb_fnd_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  digit;
    logic [7:0]  font;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        frame_valid;
    logic        seg_error;
    logic        timeout;

    always #5 clk = ~clk;

    fnd_scan_decoder #(
        .STABLE_CYCLES (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_digit      (digit),
        .i_font       (font),
        .o_value      (value),
        .o_dp         (dp),
        .o_blank      (blank),
        .o_frame_valid(frame_valid),
        .o_seg_error  (seg_error),
        .o_timeout    (timeout)
    );

    localparam logic [1:0] K_FRAME = 2'd0;
    localparam logic [1:0] K_ERR   = 2'd1;
    localparam logic [1:0] K_TMO   = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } ev_t;

    typedef struct {
        logic [3:0] digit;
        logic [7:0] font;
        logic       err;
        logic [3:0] nib;
        logic       dp;
        logic       blank;
    } vec_t;

    ev_t  sb[$];
    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    ev_t        got;
    logic [1:0] kind_act;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        ev_t e;
        e.kind  = k;
        e.value = v;
        e.dp    = d;
        e.blank = b;
        sb.push_back(e);
    endtask

    task automatic add(input logic [3:0] d, input logic [7:0] f, input logic err,
                       input logic [3:0] nib, input logic p, input logic b);
        vec_t v;
        v.digit = d;
        v.font  = f;
        v.err   = err;
        v.nib   = nib;
        v.dp    = p;
        v.blank = b;
        vecs.push_back(v);
    endtask

    // Present a pair for exactly n rising edges.
    task automatic step(input logic [3:0] d, input logic [7:0] f, input int n);
        digit = d;
        font  = f;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan4(input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2, input logic [7:0] f3);
        step(4'hE, f0, 8);
        step(4'hD, f1, 8);
        step(4'hB, f2, 8);
        step(4'h7, f3, 8);
    endtask

    task automatic drain(input string name);
        step(4'hF, 8'hFF, 6);
        chk(name, sb.size(), 0);
    endtask

    // Every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (frame_valid || seg_error || timeout) begin
            kind_act = frame_valid ? K_FRAME : (seg_error ? K_ERR : K_TMO);
            checks++;
            if ($countones({frame_valid, seg_error, timeout}) > 1) begin
                errors++;
                $display("FAIL pulse_overlap: actual=%b required=one-hot", {frame_valid, seg_error, timeout});
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: actual kind=%0d required none", kind_act);
            end else begin
                got = sb.pop_front();
                if (got.kind != kind_act) begin
                    errors++;
                    $display("FAIL pulse_kind: actual=%0d required=%0d", kind_act, got.kind);
                end else if (kind_act == K_FRAME) begin
                    checks++;
                    if ({value, dp, blank} !== {got.value, got.dp, got.blank}) begin
                        errors++;
                        $display("FAIL frame_data: actual value=%h dp=%b blank=%b required value=%h dp=%b blank=%b",
                                 value, dp, blank, got.value, got.dp, got.blank);
                    end
                end
            end
        end
    end

    logic [3:0] sel [4];
    int         n;

    initial begin
        sel = '{4'hE, 4'hD, 4'hB, 4'h7};

        add(4'hE, 8'hC0, 0, 4'h0, 0, 0);
        add(4'hD, 8'hF9, 0, 4'h1, 0, 0);
        add(4'hB, 8'hA4, 0, 4'h2, 0, 0);
        add(4'h7, 8'hB0, 0, 4'h3, 0, 0);
        add(4'hE, 8'h99, 0, 4'h4, 0, 0);
        add(4'hD, 8'h92, 0, 4'h5, 0, 0);
        add(4'hB, 8'h82, 0, 4'h6, 0, 0);
        add(4'h7, 8'hF8, 0, 4'h7, 0, 0);
        add(4'hE, 8'h80, 0, 4'h8, 0, 0);
        add(4'hD, 8'h90, 0, 4'h9, 0, 0);
        add(4'hB, 8'h88, 0, 4'hA, 0, 0);
        add(4'h7, 8'h83, 0, 4'hB, 0, 0);
        add(4'hE, 8'hC6, 0, 4'hC, 0, 0);
        add(4'hD, 8'hA1, 0, 4'hD, 0, 0);
        add(4'hB, 8'h86, 0, 4'hE, 0, 0);
        add(4'h7, 8'h8E, 0, 4'hF, 0, 0);
        add(4'hB, 8'h40, 0, 4'h0, 1, 0);
        add(4'h7, 8'h7F, 0, 4'h0, 1, 1);
        add(4'hE, 8'hFF, 0, 4'h0, 0, 1);
        add(4'hD, 8'h00, 0, 4'h8, 1, 0);
        add(4'hD, 8'hFE, 1, 4'h0, 0, 0);
        add(4'hC, 8'hC0, 1, 4'h0, 0, 0);
        add(4'h0, 8'hB0, 1, 4'h0, 0, 0);
        add(4'hE, 8'h7E, 1, 4'h0, 0, 0);
        add(4'h7, 8'hBF, 1, 4'h0, 0, 0);

        rst   = 1'b1;
        digit = 4'hF;
        font  = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {value, dp, blank, frame_valid, seg_error, timeout}, 0);
        rst = 1'b0;
        step(4'hF, 8'hFF, 6);

        // Normal frame with commit latency checked edge by edge.
        step(4'hE, 8'hB0, 8);
        step(4'hD, 8'hA4, 8);
        step(4'hB, 8'hF9, 8);
        push(K_FRAME, 16'h0123, 4'h0, 4'h0);
        step(4'h7, 8'hC0, 4);
        chk("pre_commit_fv", frame_valid, 0);
        @(posedge clk);
        #1;
        chk("commit_fv", frame_valid, 1);
        chk("commit_value", value, 16'h0123);
        step(4'h7, 8'hC0, 3);
        drain("normal_frame_sb");
        chk("value_holds", value, 16'h0123);

        // Decode table.
        foreach (vecs[i]) begin
            if (vecs[i].err) begin
                push(K_ERR, 16'h0, 4'h0, 4'h0);
                step(vecs[i].digit, vecs[i].font, 8);
                step(4'hF, 8'hFF, 4);
            end else begin
                n = (vecs[i].digit == 4'hE) ? 0 : (vecs[i].digit == 4'hD) ? 1 : (vecs[i].digit == 4'hB) ? 2 : 3;
                push(K_FRAME, 16'(vecs[i].nib) << (4 * n), 4'(vecs[i].dp) << n, 4'(vecs[i].blank) << n);
                for (int k = 0; k < 4; k++) begin
                    step(sel[k], (k == n) ? vecs[i].font : 8'hC0, 8);
                end
            end
        end
        drain("table_sb");

        // Latest accept on a digit wins.
        push(K_FRAME, 16'h0002, 4'h0, 4'h0);
        step(4'hE, 8'hF9, 8);
        step(4'hE, 8'hA4, 8);
        step(4'hD, 8'hC0, 8);
        step(4'hB, 8'hC0, 8);
        step(4'h7, 8'hC0, 8);
        drain("overwrite_sb");

        // Decimal point and dark digit.
        push(K_FRAME, 16'h0000, 4'b0100, 4'b1000);
        scan4(8'hC0, 8'hC0, 8'h40, 8'hFF);
        drain("dp_blank_sb");

        // Three-cycle glitch is rejected, so digits 1..3 alone time out.
        step(4'hE, 8'hC0, 3);
        step(4'hF, 8'hFF, 4);
        step(4'hD, 8'hA4, 8);
        step(4'hB, 8'hF9, 8);
        step(4'h7, 8'hB0, 8);
        push(K_TMO, 16'h0, 4'h0, 4'h0);
        step(4'hF, 8'hFF, 110);
        chk("glitch_sb", sb.size(), 0);
        push(K_FRAME, 16'h3120, 4'h0, 4'h0);
        step(4'hE, 8'hC0, 4);
        step(4'hF, 8'hFF, 4);
        step(4'hD, 8'hA4, 8);
        step(4'hB, 8'hF9, 8);
        step(4'h7, 8'hB0, 8);
        drain("four_cycle_accept_sb");

        // Illegal font inside a frame leaves its slot unseen.
        push(K_ERR, 16'h0, 4'h0, 4'h0);
        push(K_TMO, 16'h0, 4'h0, 4'h0);
        step(4'hE, 8'hB0, 8);
        step(4'hD, 8'hA4, 8);
        step(4'hB, 8'hFE, 8);
        step(4'h7, 8'hC0, 8);
        step(4'hF, 8'hFF, 110);
        drain("err_in_frame_sb");

        // Timeout of a partial frame, then partial rescan, then full rescan.
        step(4'hE, 8'hB0, 8);
        step(4'hD, 8'hA4, 8);
        push(K_TMO, 16'h0, 4'h0, 4'h0);
        step(4'hF, 8'hFF, 100);
        chk("timeout_fired", sb.size(), 0);
        step(4'hB, 8'hF9, 8);
        step(4'h7, 8'hC0, 8);
        push(K_TMO, 16'h0, 4'h0, 4'h0);
        step(4'hF, 8'hFF, 110);
        chk("partial_rescan_sb", sb.size(), 0);
        push(K_FRAME, 16'h0123, 4'h0, 4'h0);
        scan4(8'hB0, 8'hA4, 8'hF9, 8'hC0);
        drain("full_rescan_sb");

        // Reset mid-frame discards the partial frame and clears the outputs.
        step(4'hE, 8'hB0, 8);
        step(4'hD, 8'hA4, 8);
        step(4'hB, 8'hF9, 8);
        step(4'hF, 8'hFF, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(4'h7, 8'hC0, 8);
        chk("reset_mid_value", value, 16'h0000);
        chk("reset_mid_dp_blank", {dp, blank}, 8'h00);
        chk("reset_mid_pulses", {frame_valid, seg_error, timeout}, 3'b000);
        push(K_TMO, 16'h0, 4'h0, 4'h0);
        step(4'hF, 8'hFF, 110);
        push(K_FRAME, 16'h0123, 4'h0, 4'h0);
        scan4(8'hB0, 8'hA4, 8'hF9, 8'hC0);
        drain("post_reset_sb");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
